// File: rtl/pix_pkg.sv
// Shared pixel/word definitions for the 240-bit pixel buffer path.
package pix_pkg;

  localparam int unsigned PIX_WIDTH      = 24;
  localparam int unsigned PIX_PER_WORD   = 10;
  localparam int unsigned WORD_WIDTH     = PIX_WIDTH * PIX_PER_WORD;
  localparam int unsigned DROP_CNT_WIDTH = 16;
  localparam int unsigned SLOT_WIDTH     = $clog2(PIX_PER_WORD);
  localparam int unsigned SHAMT_WIDTH    = $clog2(WORD_WIDTH);

  // RGB888 pixel, red in the most significant byte
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef logic [WORD_WIDTH-1:0]     word_t;
  typedef logic [DROP_CNT_WIDTH-1:0] drop_cnt_t;

endpackage

// File: rtl/pix_pack_240_if.sv
// Pixel input, FIFO write side and overflow status of the pixel packer.
interface pix_pack_240_if;
  import pix_pkg::*;

  logic      pix_vld;
  pixel_t    pix_data;
  logic      pix_sof;
  logic      pix_eol;
  logic      wr_en;
  word_t     wr_data;
  logic      wr_vld;
  logic      ovf_clr;
  logic      ovf;
  drop_cnt_t drop_cnt;

  // Packer side
  modport slave (
    input  pix_vld, pix_data, pix_sof, pix_eol, wr_vld, ovf_clr,
    output wr_en, wr_data, ovf, drop_cnt
  );

  // Pixel source / FIFO / control side
  modport master (
    output pix_vld, pix_data, pix_sof, pix_eol, wr_vld, ovf_clr,
    input  wr_en, wr_data, ovf, drop_cnt
  );

endinterface

// File: rtl/pix_pack_240.sv
// Packs ten 24-bit pixels LSB-first into a 240-bit FIFO word, with a hold
// register to ride out FIFO backpressure and a saturating dropped-word count.
module pix_pack_240
  import pix_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  pix_pack_240_if.slave  bus
);

  word_t                  r_acc;
  logic [SLOT_WIDTH-1:0]  r_slot;
  word_t                  r_hold;
  logic                   r_hold_vld;
  logic                   r_ovf;
  drop_cnt_t              r_drop_cnt;

  logic [SLOT_WIDTH-1:0]  w_slot_eff;
  logic [SHAMT_WIDTH-1:0] w_shamt;
  word_t                  w_word;
  logic                   w_complete;
  logic                   w_drain;
  logic                   w_load;
  logic                   w_drop;

  // Merge the incoming pixel into the word; sof restarts from an empty word.
  // Slots above the current one are always zero, so OR-ing is sufficient.
  always_comb begin
    w_slot_eff = bus.pix_sof ? '0 : r_slot;
    w_shamt    = SHAMT_WIDTH'(w_slot_eff) * SHAMT_WIDTH'(PIX_WIDTH);
    w_word     = (bus.pix_sof ? '0 : r_acc)
               | (WORD_WIDTH'(bus.pix_data) << w_shamt);
    w_complete = bus.pix_vld
               & (bus.pix_eol | (w_slot_eff == SLOT_WIDTH'(PIX_PER_WORD - 1)));
    w_drain    = r_hold_vld & bus.wr_vld;
    w_load     = w_complete & (~r_hold_vld | w_drain);
    w_drop     = w_complete & r_hold_vld & ~bus.wr_vld;
  end

  // Accumulator and slot pointer; cleared on every completion, kept or dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_slot <= '0;
    end else if (bus.pix_vld) begin
      if (w_complete) begin
        r_acc  <= '0;
        r_slot <= '0;
      end else begin
        r_acc  <= w_word;
        r_slot <= w_slot_eff + SLOT_WIDTH'(1);
      end
    end
  end

  // Hold register: refilled in the same cycle it drains, so no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_load) begin
      r_hold     <= w_word;
      r_hold_vld <= 1'b1;
    end else if (w_drain) begin
      r_hold_vld <= 1'b0;
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (bus.ovf_clr) begin
        r_drop_cnt <= DROP_CNT_WIDTH'(1);
      end else if (!(&r_drop_cnt)) begin
        r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
      end
    end else if (bus.ovf_clr) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign bus.wr_en    = r_hold_vld & bus.wr_vld;
  assign bus.wr_data  = r_hold;
  assign bus.ovf      = r_ovf;
  assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pix_pack_240.sv
// Directed and random stimulus for pix_pack_240 against a queue-based model.
module tb_pix_pack_240;
  import pix_pkg::*;

  logic clk;
  logic rst_n;

  pix_pack_240_if bif ();

  pix_pack_240 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int errors;

  // Reference model: pixels of the word being collected, plus hold/status
  logic [PIX_WIDTH-1:0] cur [$];
  word_t                m_hold;
  bit                   m_hv;
  bit                   m_ovf;
  drop_cnt_t            m_cnt;

  // Observed FIFO writes
  word_t wq [$];
  bit    last_en;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t pack_cur();
    word_t w;
    w = '0;
    foreach (cur[i]) w[i*PIX_WIDTH +: PIX_WIDTH] = cur[i];
    return w;
  endfunction

  task automatic model_reset();
    cur.delete();
    m_hold = '0;
    m_hv   = 1'b0;
    m_ovf  = 1'b0;
    m_cnt  = '0;
  endtask

  task automatic model_step(input bit v, input logic [PIX_WIDTH-1:0] d,
                            input bit sof, input bit eol, input bit wrv, input bit clr);
    bit    drain;
    bit    loaded;
    bit    dropped;
    word_t w;
    drain   = m_hv && wrv;
    loaded  = 1'b0;
    dropped = 1'b0;
    if (v) begin
      if (sof) cur.delete();
      cur.push_back(d);
      if (cur.size() == int'(PIX_PER_WORD) || eol) begin
        w = pack_cur();
        cur.delete();
        if (!m_hv || drain) begin
          m_hold = w;
          loaded = 1'b1;
        end else begin
          dropped = 1'b1;
        end
      end
    end
    if (loaded) m_hv = 1'b1;
    else if (drain) m_hv = 1'b0;
    if (dropped) begin
      m_ovf = 1'b1;
      if (clr) m_cnt = 16'd1;
      else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (clr) begin
      m_ovf = 1'b0;
      m_cnt = '0;
    end
  endtask

  // One clock cycle: drive, compare outputs against the model, then advance it
  task automatic cyc(input bit v, input logic [PIX_WIDTH-1:0] d,
                     input bit sof, input bit eol, input bit wrv, input bit clr);
    @(negedge clk);
    bif.pix_vld  = v;
    bif.pix_data = d;
    bif.pix_sof  = sof;
    bif.pix_eol  = eol;
    bif.wr_vld   = wrv;
    bif.ovf_clr  = clr;
    #1;
    chk("wr_en",    WORD_WIDTH'(bif.wr_en),    WORD_WIDTH'(m_hv && wrv));
    chk("wr_data",  bif.wr_data,               m_hold);
    chk("ovf",      WORD_WIDTH'(bif.ovf),      WORD_WIDTH'(m_ovf));
    chk("drop_cnt", WORD_WIDTH'(bif.drop_cnt), WORD_WIDTH'(m_cnt));
    last_en = (bif.wr_en === 1'b1);
    if (last_en) wq.push_back(bif.wr_data);
    model_step(v, d, sof, eol, wrv, clr);
  endtask

  function automatic word_t seq_word(input int base, input int n);
    word_t w;
    w = '0;
    for (int k = 0; k < n; k++) w[k*PIX_WIDTH +: PIX_WIDTH] = PIX_WIDTH'(base + k);
    return w;
  endfunction

  initial begin
    int    pos [$];
    word_t exp;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bif.pix_vld  = 1'b0;
    bif.pix_data = '0;
    bif.pix_sof  = 1'b0;
    bif.pix_eol  = 1'b0;
    bif.wr_vld   = 1'b1;
    bif.ovf_clr  = 1'b0;
    model_reset();

    // Reset values with wr_vld high
    @(negedge clk);
    #1;
    chk("rst_wr_en",    WORD_WIDTH'(bif.wr_en),    '0);
    chk("rst_wr_data",  bif.wr_data,               '0);
    chk("rst_ovf",      WORD_WIDTH'(bif.ovf),      '0);
    chk("rst_drop_cnt", WORD_WIDTH'(bif.drop_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous pixels 1..30, no eol: writes one cycle after pixels 10/20/30
    wq.delete();
    for (int i = 1; i <= 31; i++) begin
      if (i <= 30) cyc(1'b1, PIX_WIDTH'(i), 1'b0, 1'b0, 1'b1, 1'b0);
      else         cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (last_en) pos.push_back(i);
    end
    chk("cont_nwr",  WORD_WIDTH'(wq.size()), WORD_WIDTH'(3));
    chk("cont_pos0", WORD_WIDTH'(pos[0]), WORD_WIDTH'(11));
    chk("cont_pos1", WORD_WIDTH'(pos[1]), WORD_WIDTH'(21));
    chk("cont_pos2", WORD_WIDTH'(pos[2]), WORD_WIDTH'(31));
    chk("cont_word0", wq[0], seq_word(1, 10));
    chk("cont_word2", wq[2], seq_word(21, 10));

    // 13-pixel line with eol: second word is three pixels, zero padded
    wq.delete();
    for (int i = 1; i <= 13; i++)
      cyc(1'b1, PIX_WIDTH'(32'h100 + i), i == 1, i == 13, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("eol_nwr", WORD_WIDTH'(wq.size()), WORD_WIDTH'(2));
    exp = '0;
    exp[71:0] = {24'h10D, 24'h10C, 24'h10B};
    chk("eol_word1", wq[1], exp);

    // 25 cycles of backpressure: first word held, second dropped
    wq.delete();
    for (int i = 1; i <= 25; i++)
      cyc(1'b1, PIX_WIDTH'(32'h200 + i), i == 1, 1'b0, 1'b0, 1'b0);
    chk("bp_nowrite", WORD_WIDTH'(wq.size()), '0);
    chk("bp_drop_cnt", WORD_WIDTH'(bif.drop_cnt), WORD_WIDTH'(1));
    chk("bp_ovf", WORD_WIDTH'(bif.ovf), WORD_WIDTH'(1));
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_held_word", wq[0], seq_word(32'h201, 10));
    cyc(1'b1, 24'h2FF, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", WORD_WIDTH'(bif.ovf), '0);
    chk("clr_cnt", WORD_WIDTH'(bif.drop_cnt), '0);

    // Completion coincident with drain: no drop, back-to-back writes
    wq.delete();
    pos.delete();
    for (int i = 1; i <= 21; i++) begin
      if (i <= 20) cyc(1'b1, PIX_WIDTH'(32'h300 + i), i == 1, 1'b0, i == 20, 1'b0);
      else         cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (last_en) pos.push_back(i);
    end
    chk("drain_nwr", WORD_WIDTH'(wq.size()), WORD_WIDTH'(2));
    chk("drain_pos0", WORD_WIDTH'(pos[0]), WORD_WIDTH'(20));
    chk("drain_pos1", WORD_WIDTH'(pos[1]), WORD_WIDTH'(21));
    chk("drain_word1", wq[1], seq_word(32'h30B, 10));
    chk("drain_nodrop", WORD_WIDTH'(bif.drop_cnt), '0);

    // sof after four pixels discards them without counting a drop
    wq.delete();
    for (int i = 1; i <= 4; i++) cyc(1'b1, PIX_WIDTH'(32'h400 + i), 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, PIX_WIDTH'(32'h500 + i), i == 0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 24'h777, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("sof_word", wq[0], seq_word(32'h500, 10));
    chk("sof_eol_word", wq[1], WORD_WIDTH'(24'h777));
    chk("sof_nodrop", WORD_WIDTH'(bif.drop_cnt), '0);

    // ovf_clr coincident with a drop leaves the count at one
    for (int i = 0; i < 10; i++) cyc(1'b1, PIX_WIDTH'(32'h600 + i), i == 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 24'h6A0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 24'h6A1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 24'h6A2, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clrdrop_cnt", WORD_WIDTH'(bif.drop_cnt), WORD_WIDTH'(1));
    chk("clrdrop_ovf", WORD_WIDTH'(bif.ovf), WORD_WIDTH'(1));

    // Saturation: more than 65535 drops
    for (int i = 0; i < 65540; i++) cyc(1'b1, PIX_WIDTH'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt", WORD_WIDTH'(bif.drop_cnt), WORD_WIDTH'(16'hFFFF));
    chk("sat_ovf", WORD_WIDTH'(bif.ovf), WORD_WIDTH'(1));

    // Asynchronous reset mid-word with a held word and a set overflow flag
    for (int i = 0; i < 3; i++) cyc(1'b1, PIX_WIDTH'(32'h700 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bif.pix_vld = 1'b0;
    bif.ovf_clr = 1'b0;
    bif.wr_vld  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en",    WORD_WIDTH'(bif.wr_en),    '0);
    chk("arst_wr_data",  bif.wr_data,               '0);
    chk("arst_ovf",      WORD_WIDTH'(bif.ovf),      '0);
    chk("arst_drop_cnt", WORD_WIDTH'(bif.drop_cnt), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    for (int i = 0; i < 10; i++) cyc(1'b1, PIX_WIDTH'(32'h800 + i), 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("arst_next_word", wq[0], seq_word(32'h800, 10));

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 4) != 0, PIX_WIDTH'($urandom), ($urandom % 40) == 0,
          ($urandom % 12) == 0, ($urandom % 3) != 0, ($urandom % 50) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
